// File: rtl/pixels_scanout.sv
// Read-side scan engine for the 80x64 -> 2048x4 pixel line buffer: prefetches
// buffer words into a 2-entry FIFO at clk rate and emits one pixel per pixel_ce.
module pixels_scanout #(
  parameter int LINE_PIXELS = 1280,
  parameter int ADDR_WIDTH  = 11,
  parameter int PIXEL_WIDTH = 4,
  parameter logic [PIXEL_WIDTH-1:0] BORDER = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   pixel_ce,
  output logic [ADDR_WIDTH-1:0]  addrb,
  input  logic [PIXEL_WIDTH-1:0] dob,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   pixel_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun,
  output logic [1:0]             state_dbg
);
  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam logic [CW-1:0]         LINE_CNT  = CW'(LINE_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          issued, pix_cnt;
  logic                   inflight;
  logic [PIXEL_WIDTH-1:0] fifo0, fifo1;
  logic [1:0]             fifo_cnt;
  logic [2:0]             occupancy;
  logic                   consume, line_end, pop, starve, issue;

  // Handshake: a read is issued on the edge where the buffer samples addrb;
  // its dob is pushed one edge later. Issue is allowed while FIFO entries plus
  // the read in flight, less any pop on this edge, stay below two.
  always_comb begin
    state_next = state;
    consume    = 1'b0;
    line_end   = 1'b0;
    if (start) begin
      state_next = FILL;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        FILL: begin
          if (pixel_ce) begin
            consume    = 1'b1;
            state_next = RUN;
          end else if (fifo_cnt != 2'd0) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (pixel_ce) begin
            if (pix_cnt == LINE_CNT) begin
              line_end   = 1'b1;
              state_next = IDLE;
            end else begin
              consume = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    pop       = consume && (fifo_cnt != 2'd0);
    starve    = consume && (fifo_cnt == 2'd0);
    occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state != IDLE) && !start && (issued < LINE_CNT) && (occupancy < 3'd2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addrb       <= '0;
      issued      <= '0;
      pix_cnt     <= '0;
      pixel       <= BORDER;
      pixel_valid <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= line_end;
      if (start) begin
        addrb       <= '0;
        issued      <= '0;
        pix_cnt     <= '0;
        pixel       <= BORDER;
        pixel_valid <= 1'b0;
        underrun    <= 1'b0;
      end else begin
        if (issue) begin
          issued <= issued + CW'(1);
          // addrb parks on the last pixel address rather than wrapping
          if (addrb != LAST_ADDR) addrb <= addrb + ADDR_WIDTH'(1);
        end
        if (pop) begin
          pixel       <= fifo0;
          pixel_valid <= 1'b1;
          pix_cnt     <= pix_cnt + CW'(1);
        end else if (starve || line_end) begin
          pixel       <= BORDER;
          pixel_valid <= 1'b0;
        end
        if (starve) underrun <= 1'b1;
      end
    end
  end

  // Clearing inflight on start drops the stale read whose data would land next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo0    <= '0;
      fifo1    <= '0;
      fifo_cnt <= '0;
      inflight <= 1'b0;
    end else if (start) begin
      fifo_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      case ({inflight, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo0 <= dob;
          else                  fifo1 <= dob;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo0    <= fifo1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo0 <= dob;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= dob;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
endmodule
